// File: rtl/read_channel_distributor_if.sv
// Stream bundle between the SRAM read path and the per-port output lanes.
// The master drives the input stream and the lane ready signals. The slave is the distributor.
interface read_channel_distributor_if #(
  parameter int num_of_ports       = 16,
  parameter int arbiter_data_width = 64,
  parameter int des_port_width     = 4
);
  logic                                      in_valid;
  logic                                      in_sop;
  logic                                      in_eop;
  logic [arbiter_data_width-1:0]             in_data;
  logic [des_port_width-1:0]                 in_des_port;
  logic                                      in_ready;
  logic [num_of_ports-1:0]                   out_valid;
  logic [num_of_ports-1:0]                   out_eop;
  logic [arbiter_data_width*num_of_ports-1:0] out_data;
  logic [num_of_ports-1:0]                   out_ready;

  modport master (
    output in_valid, in_sop, in_eop, in_data, in_des_port, out_ready,
    input  in_ready, out_valid, out_eop, out_data
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, in_des_port, out_ready,
    output in_ready, out_valid, out_eop, out_data
  );
endinterface

// File: rtl/read_channel_distributor.sv
// Routes each packet of the tagged read stream to the lane locked at start-of-packet.
// The lanes are fed through one registered valid/ready stage.
module read_channel_distributor #(
  parameter int num_of_ports       = 16,
  parameter int arbiter_data_width = 64,
  parameter int des_port_width     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  read_channel_distributor_if.slave bus,
  output logic                      busy,
  output logic [des_port_width-1:0] active_port,
  output logic [7:0]                drop_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [des_port_width-1:0]     lk_port_q, lk_port_d;
  logic                          ov_q, ov_d;
  logic [arbiter_data_width-1:0] word_q, word_d;
  logic [des_port_width-1:0]     reg_port_q, reg_port_d;
  logic                          reg_eop_q, reg_eop_d;
  logic [7:0]                    drop_cnt_q, drop_cnt_d;

  logic accept;
  logic drain;
  logic load;
  logic drop;

  // Pass-through ready: a draining register can take a new word in the same cycle.
  assign drain        = ov_q && bus.out_ready[reg_port_q];
  assign bus.in_ready = !ov_q || bus.out_ready[reg_port_q];
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept && (bus.in_sop || (state_q == XFER));
  assign drop         = accept && !bus.in_sop && (state_q == IDLE);

  // FSM state and port lock register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lk_port_q <= {des_port_width{1'b0}};
    end else begin
      state_q   <= state_d;
      lk_port_q <= lk_port_d;
    end
  end

  // FSM next state; a sop always relocks, even mid-packet
  always_comb begin
    state_d   = state_q;
    lk_port_d = lk_port_q;
    case (state_q)
      IDLE: begin
        if (accept && bus.in_sop) begin
          lk_port_d = bus.in_des_port;
          state_d   = bus.in_eop ? IDLE : XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (accept && bus.in_sop) begin
          lk_port_d = bus.in_des_port;
          state_d   = bus.in_eop ? IDLE : XFER;
        end else if (accept && bus.in_eop) begin
          state_d = IDLE;
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        state_d   = IDLE;
        lk_port_d = {des_port_width{1'b0}};
      end
    endcase
  end

  // FSM status outputs
  always_comb begin
    busy        = (state_q == XFER) || ov_q;
    active_port = (state_q == XFER) ? lk_port_q : {des_port_width{1'b0}};
    drop_cnt    = drop_cnt_q;
  end

  // Output register and drop counter next-state
  always_comb begin
    ov_d       = ov_q;
    word_d     = word_q;
    reg_port_d = reg_port_q;
    reg_eop_d  = reg_eop_q;
    drop_cnt_d = drop_cnt_q;
    if (load) begin
      ov_d       = 1'b1;
      word_d     = bus.in_data;
      reg_port_d = bus.in_sop ? bus.in_des_port : lk_port_q;
      reg_eop_d  = bus.in_eop;
    end else if (drain) begin
      ov_d = 1'b0;
    end else begin
      ov_d = ov_q;
    end
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Output register and drop counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q       <= 1'b0;
      word_q     <= {arbiter_data_width{1'b0}};
      reg_port_q <= {des_port_width{1'b0}};
      reg_eop_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      ov_q       <= ov_d;
      word_q     <= word_d;
      reg_port_q <= reg_port_d;
      reg_eop_q  <= reg_eop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Lane decode of the output register; only lane reg_port is ever non-zero
  always_comb begin
    bus.out_valid = {num_of_ports{1'b0}};
    bus.out_eop   = {num_of_ports{1'b0}};
    bus.out_data  = {(arbiter_data_width*num_of_ports){1'b0}};
    for (int i = 0; i < num_of_ports; i++) begin
      if (reg_port_q == des_port_width'(i)) begin
        bus.out_valid[i]                                     = ov_q;
        bus.out_eop[i]                                       = ov_q && reg_eop_q;
        bus.out_data[i*arbiter_data_width +: arbiter_data_width] = word_q;
      end else begin
        bus.out_valid[i]                                     = 1'b0;
        bus.out_eop[i]                                       = 1'b0;
        bus.out_data[i*arbiter_data_width +: arbiter_data_width] = {arbiter_data_width{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_read_channel_distributor.sv
// Directed bench for read_channel_distributor. The expected values are worked out by hand from the packet sequences.
module tb_read_channel_distributor;
  logic       clk;
  logic       rst;
  logic       busy;
  logic [3:0] active_port;
  logic [7:0] drop_cnt;
  int         n_total;
  int         n_bad;
  logic       seen_valid;

  read_channel_distributor_if #(.num_of_ports(16), .arbiter_data_width(64), .des_port_width(4)) bus ();

  read_channel_distributor #(.num_of_ports(16), .arbiter_data_width(64), .des_port_width(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .busy        (busy),
    .active_port (active_port),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lane(input int i);
    return bus.out_data[i*64 +: 64];
  endfunction

  // Drive one input beat, then step to just after the next rising edge.
  task automatic beat(input logic v, input logic s, input logic e,
                      input logic [63:0] d, input logic [3:0] p);
    bus.in_valid    = v;
    bus.in_sop      = s;
    bus.in_eop      = e;
    bus.in_data     = d;
    bus.in_des_port = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total         = 0;
    n_bad           = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_sop      = 1'b0;
    bus.in_eop      = 1'b0;
    bus.in_data     = 64'd0;
    bus.in_des_port = 4'd0;
    bus.out_ready   = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_valid",    {48'd0, bus.out_valid}, 64'd0);
    chk("rst_eop",      {48'd0, bus.out_eop}, 64'd0);
    chk("rst_data",     {63'd0, |bus.out_data}, 64'd0);
    chk("rst_busy",     {63'd0, busy}, 64'd0);
    chk("rst_active",   {60'd0, active_port}, 64'd0);
    chk("rst_drop",     {56'd0, drop_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Four-word packet to lane 5 at full rate
    beat(1'b1, 1'b1, 1'b0, 64'hD0D0_0000_0000_0000, 4'd5);
    chk("p5_v0", {48'd0, bus.out_valid}, 64'h0020);
    chk("p5_d0", lane(5), 64'hD0D0_0000_0000_0000);
    chk("p5_e0", {48'd0, bus.out_eop}, 64'h0000);
    chk("p5_act", {60'd0, active_port}, 64'd5);
    chk("p5_busy", {63'd0, busy}, 64'd1);
    beat(1'b1, 1'b0, 1'b0, 64'hD1D1_0000_0000_0001, 4'd0);
    chk("p5_v1", {48'd0, bus.out_valid}, 64'h0020);
    chk("p5_d1", lane(5), 64'hD1D1_0000_0000_0001);
    beat(1'b1, 1'b0, 1'b0, 64'hD2D2_0000_0000_0002, 4'd0);
    chk("p5_d2", lane(5), 64'hD2D2_0000_0000_0002);
    chk("p5_e2", {48'd0, bus.out_eop}, 64'h0000);
    beat(1'b1, 1'b0, 1'b1, 64'hD3D3_0000_0000_0003, 4'd0);
    chk("p5_v3", {48'd0, bus.out_valid}, 64'h0020);
    chk("p5_d3", lane(5), 64'hD3D3_0000_0000_0003);
    chk("p5_e3", {48'd0, bus.out_eop}, 64'h0020);
    chk("p5_act_idle", {60'd0, active_port}, 64'd0);
    beat(1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("p5_drained", {48'd0, bus.out_valid}, 64'h0000);
    chk("p5_busy_off", {63'd0, busy}, 64'd0);

    // Same packet with lane 5 stalled for three cycles; other lanes' ready must not matter
    beat(1'b1, 1'b1, 1'b0, 64'hE0E0_0000_0000_0000, 4'd5);
    chk("bp_d0", lane(5), 64'hE0E0_0000_0000_0000);
    bus.out_ready   = 16'hFFDF;
    bus.in_valid    = 1'b1;
    bus.in_sop      = 1'b0;
    bus.in_eop      = 1'b0;
    bus.in_data     = 64'hE1E1_0000_0000_0001;
    #1;
    chk("bp_ready0", {63'd0, bus.in_ready}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_d", lane(5), 64'hE0E0_0000_0000_0000);
      chk("bp_hold_v", {48'd0, bus.out_valid}, 64'h0020);
      chk("bp_hold_rdy", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 16'hFFFF;
    beat(1'b1, 1'b0, 1'b0, 64'hE1E1_0000_0000_0001, 4'd0);
    chk("bp_d1", lane(5), 64'hE1E1_0000_0000_0001);
    beat(1'b1, 1'b0, 1'b0, 64'hE2E2_0000_0000_0002, 4'd0);
    chk("bp_d2", lane(5), 64'hE2E2_0000_0000_0002);
    beat(1'b1, 1'b0, 1'b1, 64'hE3E3_0000_0000_0003, 4'd0);
    chk("bp_d3", lane(5), 64'hE3E3_0000_0000_0003);
    chk("bp_e3", {48'd0, bus.out_eop}, 64'h0020);
    beat(1'b0, 1'b0, 1'b0, 64'd0, 4'd0);

    // Back-to-back packets: lane 2 eop, then lane 9 sop on the very next cycle
    beat(1'b1, 1'b1, 1'b0, 64'hA0A0_0000_0000_0000, 4'd2);
    beat(1'b1, 1'b0, 1'b1, 64'hA1A1_0000_0000_0001, 4'd0);
    chk("b2b_v2", {48'd0, bus.out_valid}, 64'h0004);
    chk("b2b_e2", {48'd0, bus.out_eop}, 64'h0004);
    chk("b2b_d2", lane(2), 64'hA1A1_0000_0000_0001);
    beat(1'b1, 1'b1, 1'b0, 64'hB0B0_0000_0000_0000, 4'd9);
    chk("b2b_v9", {48'd0, bus.out_valid}, 64'h0200);
    chk("b2b_d9", lane(9), 64'hB0B0_0000_0000_0000);
    chk("b2b_e9", {48'd0, bus.out_eop}, 64'h0000);
    chk("b2b_act9", {60'd0, active_port}, 64'd9);
    beat(1'b1, 1'b0, 1'b1, 64'hB1B1_0000_0000_0001, 4'd0);
    chk("b2b_e9b", {48'd0, bus.out_eop}, 64'h0200);
    chk("b2b_d9b", lane(9), 64'hB1B1_0000_0000_0001);
    beat(1'b0, 1'b0, 1'b0, 64'd0, 4'd0);

    // Single-word packet to lane 15, held one cycle so busy covers the undrained register
    bus.out_ready = 16'h7FFF;
    beat(1'b1, 1'b1, 1'b1, 64'hF0F0_F0F0_0000_000F, 4'd15);
    chk("sw_v", {48'd0, bus.out_valid}, 64'h8000);
    chk("sw_e", {48'd0, bus.out_eop}, 64'h8000);
    chk("sw_d", lane(15), 64'hF0F0_F0F0_0000_000F);
    chk("sw_act", {60'd0, active_port}, 64'd0);
    chk("sw_busy", {63'd0, busy}, 64'd1);
    beat(1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("sw_busy_hold", {63'd0, busy}, 64'd1);
    bus.out_ready = 16'hFFFF;
    beat(1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("sw_busy_off", {63'd0, busy}, 64'd0);
    chk("sw_drained", {48'd0, bus.out_valid}, 64'h0000);

    // 300 words outside any packet: all dropped, counter saturates
    beat(1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_0BAD, 4'd4);
    chk("drop_1", {56'd0, drop_cnt}, 64'd1);
    seen_valid = |bus.out_valid;
    for (int k = 0; k < 299; k++) begin
      beat(1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_0BAD, 4'd4);
      seen_valid = seen_valid | (|bus.out_valid);
    end
    chk("drop_sat", {56'd0, drop_cnt}, 64'd255);
    chk("drop_no_valid", {63'd0, seen_valid}, 64'd0);

    // Reset in the middle of a packet clears everything, including the lock
    beat(1'b1, 1'b1, 1'b0, 64'h6060_0000_0000_0000, 4'd3);
    beat(1'b1, 1'b0, 1'b0, 64'h6161_0000_0000_0001, 4'd0);
    chk("mid_act", {60'd0, active_port}, 64'd3);
    rst = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 64'h6262_0000_0000_0002, 4'd0);
    chk("mrst_valid", {48'd0, bus.out_valid}, 64'd0);
    chk("mrst_eop", {48'd0, bus.out_eop}, 64'd0);
    chk("mrst_data", {63'd0, |bus.out_data}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_act", {60'd0, active_port}, 64'd0);
    chk("mrst_drop", {56'd0, drop_cnt}, 64'd0);
    chk("mrst_rdy", {63'd0, bus.in_ready}, 64'd1);
    rst = 1'b0;
    beat(1'b1, 1'b0, 1'b0, 64'h6363_0000_0000_0003, 4'd0);
    chk("post_rst_drop", {56'd0, drop_cnt}, 64'd1);
    chk("post_rst_valid", {48'd0, bus.out_valid}, 64'd0);

    // Relock: sop to lane 7 arrives while lane 3 packet is open
    beat(1'b1, 1'b1, 1'b0, 64'hC0C0_0000_0000_0000, 4'd3);
    beat(1'b1, 1'b0, 1'b0, 64'hC1C1_0000_0000_0001, 4'd0);
    chk("rl_d3", lane(3), 64'hC1C1_0000_0000_0001);
    chk("rl_act3", {60'd0, active_port}, 64'd3);
    beat(1'b1, 1'b1, 1'b0, 64'hC2C2_0000_0000_0002, 4'd7);
    chk("rl_v7", {48'd0, bus.out_valid}, 64'h0080);
    chk("rl_d7", lane(7), 64'hC2C2_0000_0000_0002);
    chk("rl_lane3_clr", lane(3), 64'd0);
    chk("rl_act7", {60'd0, active_port}, 64'd7);
    beat(1'b1, 1'b0, 1'b1, 64'hC3C3_0000_0000_0003, 4'd0);
    chk("rl_e7", {48'd0, bus.out_eop}, 64'h0080);
    chk("rl_d7b", lane(7), 64'hC3C3_0000_0000_0003);
    chk("rl_act_idle", {60'd0, active_port}, 64'd0);
    beat(1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("rl_drained", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
